mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Sequencer that reuses one Adder_8bit to perform 8x8 unsigned shift-and-add multiplication.
//  It latches the operands on start, then drives the adder once per cycle, one multiplier bit per iteration.
//  It returns a 16-bit product with a start/busy/done handshake.
//  Sits between ALU op decode and the shared adder; the ALU issues MUL through this block.
// PARAMETERS
//  WIDTH       8  operand width; must equal Adder_8bit width (only 8 supported)
//  DONE_PULSE  1  1: done is a single-cycle pulse; 0: done held until next accepted start
// PORTS
//  clk      in   1   rising-edge clock
//  rst      in   1   asynchronous reset, active-high
//  start    in   1   request; sampled on rising edge of clk when not busy
//  num_1    in   8   multiplicand, sampled with start
//  num_2    in   8   multiplier, sampled with start
//  busy     out  1   high while iterating (state RUN)
//  done     out  1   product valid indication
//  product  out  16  num_1*num_2, registered; held until next accepted start
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, done=0, product=16'h0000; A, P_hi, Q, count cleared.
//  States: IDLE, RUN, DONE.
//   IDLE/DONE + start=1 @edge k -> RUN; latch A=num_1, Q=num_2, P_hi=0, count=0; done cleared.
//   RUN: one iteration per edge.
//   DONE (DONE_PULSE=1): -> IDLE next edge unless start=1.
//   DONE (DONE_PULSE=0): stays until start.
//  Iteration (each RUN edge):
//   - Adder_8bit inputs: num_1=P_hi, num_2=(Q[0] ? A : 8'h00), c=1'b0.
//   - {carry,sum} is the 9-bit partial result.
//   - P_hi <= {carry,sum[7:1]}; Q <= {sum[0],Q[7:1]}; count <= count+1.
//  Termination: when count reaches 8 on an edge -> DONE; product <= {P_hi,Q} (new values); done=1.
//  Latency: start accepted at edge k; done=1 and product valid after edge k+8; busy=1 after edges k..k+7.
//  start while busy: ignored; operands not resampled; no error flag.
//  start in DONE state: accepted; done drops at the same edge; product retains old value until new DONE.
//  start and reset together: reset wins.
//  Reset mid-operation: immediate abort, all outputs to reset values, no partial product visible.
//  Arithmetic: unsigned only; product never overflows 16 bits (max 0xFF*0xFF=0xFE01).
//  Adder carry-out is always consumed as P_hi bit 7; no carry leaks across iterations.
// CONFIGURATION
//  Macro MUL_EARLY_TERM_EN:
//   Defined: after each iteration, if the unprocessed multiplier bits are all zero, go to DONE that edge.
//    Unprocessed bits = Q[6-count_old:0] (count_old is count before the iteration); the last iteration always ends.
//    Capture: product <= {P_hi,Q} >> (8-count_new).
//    Latency = max(1, index of highest set bit of num_2 + 1) cycles.
//   Undefined: fixed 8 iterations regardless of operands; no shifter is synthesized.
//  Results are identical in both builds; only latency differs.
// TESTING
//  1. num_1=0xFF, num_2=0xFF, start 1 cycle -> busy 8 cycles; product=0xFE01, done after edge k+8.
//  2. num_1=0x0D, num_2=0x0B -> product=0x008F.
//     With MUL_EARLY_TERM_EN: done after edge k+4.
//  3. num_2=0x00, num_1=0x5A -> product=0x0000.
//     Fixed build: done after k+8. MUL_EARLY_TERM_EN: done after k+1.
//  4. Start 0x37*0x03; at edge k+3 pulse start with 0x11*0x11 -> second start ignored.
//     product=0x00A5; back-to-back start in DONE then gives 0x0121.
//  5. Start 0xAA*0x55; assert rst at cycle 4 -> busy=0, done=0, product=0 immediately.
//     A new start after rst release gives 0x3872.
//  6. DONE_PULSE=0: 0x02*0x03 -> done stays 1 with product=0x0006 until next start; DONE_PULSE=1: exactly 1 cycle.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// 8x8 unsigned shift-and-add multiplier sequencer that time-shares one Adder_8bit (optional MUL_EARLY_TERM_EN).
// Latency: product/done registered 8 edges after the accepted start (MUL_EARLY_TERM_EN: highest set multiplier bit + 1, min 1).
// Backpressure: start is only accepted out of IDLE/DONE; start while busy is silently dropped.

module Adder_8bit (
    input  logic [7:0] num_1,
    input  logic [7:0] num_2,
    input  logic       c,
    output logic [7:0] sum,
    output logic       carry
);
    // Shared 8-bit ripple adder: purely combinational, no flow control.
    assign {carry, sum} = {1'b0, num_1} + {1'b0, num_2} + {8'h00, c};
endmodule

module mul_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit DONE_PULSE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     num_1,
    input  logic [WIDTH-1:0]     num_2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     p_hi;
    logic [WIDTH-1:0]     q_q;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_carry;
    logic [WIDTH-1:0]     p_hi_nxt;
    logic [WIDTH-1:0]     q_nxt;
    logic [CW-1:0]        cnt_nxt;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   prod_nxt;

    assign add_b = q_q[0] ? a_q : '0;

    Adder_8bit u_adder (
        .num_1 (p_hi),
        .num_2 (add_b),
        .c     (1'b0),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // The 9-bit adder result and Q form one right shift, so the carry lands in P_hi[7].
    assign p_hi_nxt = {add_carry, add_sum[WIDTH-1:1]};
    assign q_nxt    = {add_sum[0], q_q[WIDTH-1:1]};
    assign cnt_nxt  = cnt + CW'(1);

`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic [CW-1:0]    shamt;

    // Untouched multiplier bits sit in the low WIDTH-cnt_nxt bits of Q.
    assign rem_mask  = {WIDTH{1'b1}} >> cnt_nxt;
    assign last_iter = (cnt_nxt == CW'(WIDTH)) || ((q_nxt & rem_mask) == '0);
    assign shamt     = CW'(WIDTH) - cnt_nxt;
    assign prod_nxt  = {p_hi_nxt, q_nxt} >> shamt;
`else
    assign last_iter = (cnt_nxt == CW'(WIDTH));
    assign prod_nxt  = {p_hi_nxt, q_nxt};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_q     <= '0;
            p_hi    <= '0;
            q_q     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        a_q   <= num_1;
                        q_q   <= num_2;
                        p_hi  <= '0;
                        cnt   <= '0;
                    end else if (state == S_DONE && DONE_PULSE) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    p_hi <= p_hi_nxt;
                    q_q  <= q_nxt;
                    cnt  <= cnt_nxt;
                    if (last_iter) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= prod_nxt;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: pulse-done instance plus a held-done instance.
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_1 = 8'h00;
    logic [7:0]  num_2 = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start_h = 1'b0;
    logic [7:0]  num_1_h = 8'h00;
    logic [7:0]  num_2_h = 8'h00;
    logic        busy_h;
    logic        done_h;
    logic [15:0] product_h;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t sb_h[$];

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(8), .DONE_PULSE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .num_1(num_1), .num_2(num_2),
        .busy(busy), .done(done), .product(product)
    );

    mul_seq_ctrl #(.WIDTH(8), .DONE_PULSE(1'b0)) dut_hold (
        .clk(clk), .rst(rst), .start(start_h), .num_1(num_1_h), .num_2(num_2_h),
        .busy(busy_h), .done(done_h), .product(product_h)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] b);
        int early_lat;
        early_lat = 1;
        for (int i = 0; i < 8; i++)
            if (b[i]) early_lat = i + 1;
`ifdef MUL_EARLY_TERM_EN
        return early_lat;
`else
        return (early_lat > 8) ? early_lat : 8;
`endif
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.prod = 16'(a) * 16'(b);
        e.lat  = exp_lat(b);
        return e;
    endfunction

    // Drive start for exactly one edge (edge k); returns #1 after edge k.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        num_1 = a;
        num_2 = b;
        start = 1'b1;
        sb.push_back(mk_exp(a, b));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // elapsed = edges already past k; returns #1 after the done edge.
    task automatic wait_done(input int elapsed);
        int   lat;
        exp_t e;
        lat = -1;
        for (int i = elapsed + 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            chk("done_timeout", {31'd0, done}, 32'd1);
            sb.delete();
        end else if (sb.size() == 0) begin
            chk("sb_empty_on_done", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("latency", lat, e.lat);
            chk("product", {16'd0, product}, {16'd0, e.prod});
            chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int   m;
        int   lat_h;
        exp_t e;
        logic [7:0] ra;
        logic [7:0] rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_done_h", {31'd0, done_h}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Max operands, then verify the pulse and the held product.
        issue(8'hFF, 8'hFF);
        wait_done(0);
        @(posedge clk); #1;
        chk("pulse_done_drops", {31'd0, done}, 32'd0);
        chk("product_held", {16'd0, product}, 32'h0000FE01);

        issue(8'h0D, 8'h0B);
        wait_done(0);
        issue(8'h5A, 8'h00);
        wait_done(0);

        // Start while busy must be ignored; then back-to-back start out of DONE.
        issue(8'h37, 8'h03);
        m = (exp_lat(8'h03) - 1 < 3) ? exp_lat(8'h03) - 1 : 3;
        for (int j = 1; j < m; j++) begin
            @(posedge clk); #1;
        end
        num_1 = 8'h11;
        num_2 = 8'h11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(m);
        issue(8'h11, 8'h11);
        chk("b2b_done_cleared", {31'd0, done}, 32'd0);
        chk("b2b_old_product", {16'd0, product}, 32'h000000A5);
        wait_done(0);

        // Reset mid-operation.
        issue(8'hAA, 8'h55);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", {16'd0, product}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        issue(8'hAA, 8'h55);
        wait_done(0);

        // Held-done instance.
        num_1_h = 8'h02;
        num_2_h = 8'h03;
        start_h = 1'b1;
        sb_h.push_back(mk_exp(8'h02, 8'h03));
        @(posedge clk); #1;
        start_h = 1'b0;
        lat_h = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_h) begin
                lat_h = i;
                break;
            end
        end
        e = sb_h.pop_front();
        chk("hold_latency", lat_h, e.lat);
        chk("hold_product", {16'd0, product_h}, {16'd0, e.prod});
        repeat (4) begin
            @(posedge clk); #1;
            chk("hold_done_stays", {31'd0, done_h}, 32'd1);
            chk("hold_product_stays", {16'd0, product_h}, 32'h00000006);
        end
        num_1_h = 8'h10;
        num_2_h = 8'h10;
        start_h = 1'b1;
        sb_h.push_back(mk_exp(8'h10, 8'h10));
        @(posedge clk); #1;
        start_h = 1'b0;
        chk("hold_done_drops_on_start", {31'd0, done_h}, 32'd0);
        chk("hold_old_product", {16'd0, product_h}, 32'h00000006);
        lat_h = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_h) begin
                lat_h = i;
                break;
            end
        end
        e = sb_h.pop_front();
        chk("hold2_latency", lat_h, e.lat);
        chk("hold2_product", {16'd0, product_h}, {16'd0, e.prod});

        // Random operands.
        for (int r = 0; r < 8; r++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb);
            wait_done(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
